// File: rtl/ipm_pkt_fifo_pkg.sv
// Shared constants and helpers for the distributed-RAM packet FIFO.
package ipm_pkt_fifo_pkg;

  // Widest pointer any legal configuration needs (ADDR_WIDTH up to 10, plus wrap bit).
  localparam int unsigned MaxPtrW = 11;

  // Reset values of the status flags.
  localparam logic RstEmpty       = 1'b1;
  localparam logic RstAlmostEmpty = 1'b1;
  localparam logic RstFull        = 1'b0;
  localparam logic RstAlmostFull  = 1'b0;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Distance from ptr_b up to ptr_a, modulo 2^pw.
  function automatic logic [MaxPtrW-1:0] level(input logic [MaxPtrW-1:0] ptr_a,
                                               input logic [MaxPtrW-1:0] ptr_b,
                                               input int unsigned        pw);
    logic [MaxPtrW-1:0] mask;
    mask = (MaxPtrW'(1) << pw) - MaxPtrW'(1);
    return (ptr_a - ptr_b) & mask;
  endfunction

  function automatic bit params_ok(input int unsigned addr_width,
                                   input int unsigned data_width,
                                   input int unsigned out_reg);
    return (addr_width >= 4) && (addr_width <= 10) &&
           (data_width >= 1) && (data_width <= 256) && (out_reg <= 1);
  endfunction

endpackage

// File: rtl/ipm_distributed_sdpram_v1_3_pkt.sv
// Single-clock simple dual-port RAM: synchronous write, asynchronous read.
module ipm_distributed_sdpram_v1_3_pkt #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ipm_distributed_sync_pkt_fifo_v1_3.sv
// Store-and-forward packet FIFO: speculative writes, commit-or-drop on packet end,
// overflow abort, packet count and optional registered FWFT output.
module ipm_distributed_sync_pkt_fifo_v1_3
  import ipm_pkt_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned OUT_REG          = 0,
  parameter int unsigned ALMOST_FULL_NUM  = 4,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_err,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic                  drop,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_water_level,
  output logic [ADDR_WIDTH:0]   pkt_cnt
);

  localparam int unsigned PW    = ptr_width(ADDR_WIDTH);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  if (!params_ok(ADDR_WIDTH, DATA_WIDTH, OUT_REG)) begin : g_param_err
    $error("ipm_distributed_sync_pkt_fifo_v1_3: illegal parameter set");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_level_q, wr_level_d, rd_level_q, rd_level_d, pkt_cnt_q, pkt_cnt_d;
  logic                  abort_q, abort_d, drop_q, drop_d, overflow_q, overflow_d;
  logic                  cmt_pend_q, commit, ram_we, pop_last, out_pop, load;
  logic                  full_q, full_d, almost_full_q, almost_full_d;
  logic                  ram_empty_q, ram_empty_d, almost_empty_q, almost_empty_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d, held_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH:0]   ram_rdata;

  ipm_distributed_sdpram_v1_3_pkt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata ({wr_last, wr_data}),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // Write side: accept, commit, error drop and overflow abort.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_cmt_d   = wr_cmt_q;
    abort_d    = abort_q;
    drop_d     = 1'b0;
    overflow_d = 1'b0;
    commit     = 1'b0;
    ram_we     = 1'b0;
    if (abort_q) begin
      // Swallow the rest of the oversized packet; its end releases the abort.
      if (wr_en && wr_last) begin
        wr_ptr_d = wr_cmt_q;
        abort_d  = 1'b0;
        drop_d   = 1'b1;
      end
    end else if (wr_en && full_q) begin
      overflow_d = 1'b1;
      if (wr_ptr_q != wr_cmt_q) begin
        // Ending word itself overflowing: drop now rather than abort the next packet.
        if (wr_last) begin
          wr_ptr_d = wr_cmt_q;
          drop_d   = 1'b1;
        end else begin
          abort_d = 1'b1;
        end
      end
    end else if (wr_en) begin
      ram_we = 1'b1;
      if (wr_last && wr_err) begin
        wr_ptr_d = wr_cmt_q;
        drop_d   = 1'b1;
      end else if (wr_last) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        wr_cmt_d = wr_ptr_q + PW'(1);
        commit   = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
  end

  // Read side: direct async FWFT or refill of the output register.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_pop     = 1'b0;
    load        = 1'b0;
    pop_last    = 1'b0;
    if (OUT_REG == 1) begin
      out_pop = rd_en && out_valid_q;
      load    = (!out_valid_q || out_pop) && !ram_empty_q;
      if (load) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        out_data_d = ram_rdata[DATA_WIDTH-1:0];
        out_last_d = ram_rdata[DATA_WIDTH];
      end
      out_valid_d = load || (out_valid_q && !out_pop);
      pop_last    = out_pop && out_last_q;
    end else if (rd_en && !ram_empty_q) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      pop_last = ram_rdata[DATA_WIDTH];
    end
  end

  // Flags, levels and packet count from next pointers. The read side compares against
  // the current committed pointer, so a commit becomes readable one cycle after it lands.
  always_comb begin
    wr_level_d     = PW'(level(MaxPtrW'(wr_ptr_d), MaxPtrW'(rd_ptr_d), PW));
    rd_level_d     = PW'(level(MaxPtrW'(wr_cmt_q), MaxPtrW'(rd_ptr_d), PW));
    full_d         = wr_level_d == PW'(Depth);
    almost_full_d  = int'(wr_level_d) + int'(ALMOST_FULL_NUM) >= int'(Depth);
    ram_empty_d    = rd_ptr_d == wr_cmt_q;
    held_d         = (OUT_REG == 1) ? out_valid_d : 1'b0;
    almost_empty_d = int'(rd_level_d) + int'(held_d) <= int'(ALMOST_EMPTY_NUM);
    pkt_cnt_d      = pkt_cnt_q;
    if (cmt_pend_q && !pop_last) begin
      pkt_cnt_d = pkt_cnt_q + PW'(1);
    end else if (!cmt_pend_q && pop_last) begin
      pkt_cnt_d = pkt_cnt_q - PW'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      wr_cmt_q       <= '0;
      rd_ptr_q       <= '0;
      abort_q        <= 1'b0;
      cmt_pend_q     <= 1'b0;
      drop_q         <= 1'b0;
      overflow_q     <= 1'b0;
      pkt_cnt_q      <= '0;
      wr_level_q     <= '0;
      rd_level_q     <= '0;
      full_q         <= RstFull;
      almost_full_q  <= RstAlmostFull;
      ram_empty_q    <= RstEmpty;
      almost_empty_q <= RstAlmostEmpty;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      wr_cmt_q       <= wr_cmt_d;
      rd_ptr_q       <= rd_ptr_d;
      abort_q        <= abort_d;
      cmt_pend_q     <= commit;
      drop_q         <= drop_d;
      overflow_q     <= overflow_d;
      pkt_cnt_q      <= pkt_cnt_d;
      wr_level_q     <= wr_level_d;
      rd_level_q     <= rd_level_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      ram_empty_q    <= ram_empty_d;
      almost_empty_q <= almost_empty_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
    end
  end

  assign full           = full_q;
  assign almost_full    = almost_full_q;
  assign wr_water_level = wr_level_q;
  assign drop           = drop_q;
  assign overflow       = overflow_q;
  assign rd_data        = (OUT_REG == 1) ? out_data_q : ram_rdata[DATA_WIDTH-1:0];
  assign rd_last        = (OUT_REG == 1) ? out_last_q : ram_rdata[DATA_WIDTH];
  assign empty          = (OUT_REG == 1) ? !out_valid_q : ram_empty_q;
  assign almost_empty   = almost_empty_q;
  assign rd_water_level = rd_level_q;
  assign pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_ipm_distributed_sync_pkt_fifo_v1_3.sv
// Two FIFOs (OUT_REG=0 and OUT_REG=1) share the write stimulus; a queue-based model
// predicts the committed packet stream and a monitor checks every popped word.
module tb_ipm_distributed_sync_pkt_fifo_v1_3;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic wr_en = 1'b0, wr_last = 1'b0, wr_err = 1'b0;
  logic [1:0] rd_en_v = '0;
  logic [1:0] full_v, af_v, drop_v, ovf_v, last_v, empty_v, ae_v;
  logic [DW-1:0] rd_data_a [2];
  logic [AW:0]   wr_lvl_a [2];
  logic [AW:0]   rd_lvl_a [2];
  logic [AW:0]   pkt_a [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ipm_distributed_sync_pkt_fifo_v1_3 #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .OUT_REG          (g),
      .ALMOST_FULL_NUM  (4),
      .ALMOST_EMPTY_NUM (4)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_last        (wr_last),
      .wr_err         (wr_err),
      .full           (full_v[g]),
      .almost_full    (af_v[g]),
      .wr_water_level (wr_lvl_a[g]),
      .drop           (drop_v[g]),
      .overflow       (ovf_v[g]),
      .rd_data        (rd_data_a[g]),
      .rd_last        (last_v[g]),
      .rd_en          (rd_en_v[g]),
      .empty          (empty_v[g]),
      .almost_empty   (ae_v[g]),
      .rd_water_level (rd_lvl_a[g]),
      .pkt_cnt        (pkt_a[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;
  int rd_mode = 0;  // 0 off, 1 random, 2 read while budget != 0
  int budget [2] = '{-1, -1};
  int seen_drop [2] = '{0, 0};
  int seen_ovf [2] = '{0, 0};
  int exp_drop = 0;
  int exp_ovf = 0;
  bit m_abort = 1'b0;
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic [8:0] open_q [$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [8:0] qpop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic int qlasts(input int d);
    int n = 0;
    if (d == 0) begin
      foreach (exp_q0[i]) n += int'(exp_q0[i][8]);
    end else begin
      foreach (exp_q1[i]) n += int'(exp_q1[i][8]);
    end
    return n;
  endfunction

  // Reference model of the write side: a packet becomes visible only when it ends well.
  task automatic put(input logic [DW-1:0] d, input logic last, input logic err);
    int held;
    held = exp_q0.size() + open_q.size();
    if (m_abort) begin
      if (last) begin
        open_q.delete();
        m_abort = 1'b0;
        exp_drop++;
      end
    end else if (held >= DEPTH) begin
      exp_ovf++;
      if (open_q.size() != 0) begin
        if (last) begin
          open_q.delete();
          exp_drop++;
        end else begin
          m_abort = 1'b1;
        end
      end
    end else if (last && err) begin
      open_q.delete();
      exp_drop++;
    end else begin
      open_q.push_back({last, d});
      if (last) begin
        foreach (open_q[i]) begin
          exp_q0.push_back(open_q[i]);
          exp_q1.push_back(open_q[i]);
        end
        open_q.delete();
      end
    end
    wr_data = d; wr_last = last; wr_err = err; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_last = 1'b0; wr_err = 1'b0;
  endtask

  // Monitor: drives rd_en and checks each popped word against the expected stream.
  initial begin
    logic en;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rd_mode == 1) en = 1'($urandom_range(0, 1));
        else if (rd_mode == 2) en = (budget[d] != 0);
        else en = 1'b0;
        rd_en_v[d] = en;
        if (drop_v[d]) seen_drop[d]++;
        if (ovf_v[d]) seen_ovf[d]++;
        if (!empty_v[d]) begin
          if (qsize(d) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_word dut%0d: got data %0h, expected empty", d, rd_data_a[d]);
          end else if (en) begin
            e = qpop(d);
            chk($sformatf("rd_data_dut%0d", d), int'(rd_data_a[d]), int'(e[7:0]));
            chk($sformatf("rd_last_dut%0d", d), int'(last_v[d]), int'(e[8]));
            if (budget[d] > 0) budget[d]--;
          end
        end
      end
    end
  end

  // Quiesce the read side, then compare every flag/level against the model.
  task automatic check_idle(input string tag);
    int n, held, wl;
    rd_mode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n = qsize(d);
      held = (d == 1 && n > 0) ? 1 : 0;
      wl = n - held + open_q.size();
      chk($sformatf("%s_empty_dut%0d", tag, d), int'(empty_v[d]), int'(n == 0));
      chk($sformatf("%s_rd_level_dut%0d", tag, d), int'(rd_lvl_a[d]), n - held);
      chk($sformatf("%s_wr_level_dut%0d", tag, d), int'(wr_lvl_a[d]), wl);
      chk($sformatf("%s_pkt_cnt_dut%0d", tag, d), int'(pkt_a[d]), qlasts(d));
      chk($sformatf("%s_almost_empty_dut%0d", tag, d), int'(ae_v[d]), int'(n <= 4));
      chk($sformatf("%s_full_dut%0d", tag, d), int'(full_v[d]), int'(wl == DEPTH));
      chk($sformatf("%s_almost_full_dut%0d", tag, d), int'(af_v[d]), int'(wl >= DEPTH - 4));
      chk($sformatf("%s_drops_dut%0d", tag, d), seen_drop[d], exp_drop);
      chk($sformatf("%s_overflows_dut%0d", tag, d), seen_ovf[d], exp_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    budget[0] = -1; budget[1] = -1; rd_mode = 2;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_drain_in_time"}, int'(k < 300), 1);
    check_idle(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, k, len, waited;
    bit err;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    // 3-word packet: FWFT latency of both output styles, then burst read.
    put(8'h11, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0);
    chk("s1_empty_before_commit", int'(empty_v[0]), 1);
    put(8'h33, 1'b1, 1'b0);
    lat0 = -1; lat1 = -1; k = 0;
    while ((lat0 < 0 || lat1 < 0) && k < 10) begin
      @(negedge clk);
      k++;
      if (!empty_v[0] && lat0 < 0) lat0 = k;
      if (!empty_v[1] && lat1 < 0) lat1 = k;
    end
    chk("s1_latency_outreg0", lat0, 2);
    chk("s1_latency_outreg1", lat1, 3);
    chk("s1_pkt_cnt_before_read", int'(pkt_a[0]), 1);
    @(posedge clk); #1;
    budget[0] = -1; budget[1] = -1; rd_mode = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s1_outreg1_no_bubble", int'(empty_v[1]), 0);
    end
    @(posedge clk); #1;
    check_idle("s1");

    // Errored packet must vanish.
    for (int i = 0; i < 5; i++) put(8'(8'h40 + i), 1'(i == 4), 1'(i == 4));
    chk("s2_drop_pulse", int'(drop_v[0]), 1);
    check_idle("s2");

    // Oversized packet: full, overflow, abort, drop; then a good packet.
    for (int i = 1; i <= 20; i++) begin
      put(8'(i), 1'(i == 20), 1'b0);
      if (i == 16) chk("s3_full_at_16", int'(full_v[0]), 1);
      if (i == 16) chk("s3_level_at_16", int'(wr_lvl_a[1]), 16);
      if (i == 17) chk("s3_overflow_pulse", int'(ovf_v[1]), 1);
      if (i == 19) chk("s3_abort_holds_full", int'(full_v[1]), 1);
      if (i == 20) chk("s3_drop_pulse", int'(drop_v[0]), 1);
      if (i == 20) chk("s3_level_after_drop", int'(wr_lvl_a[0]), 0);
    end
    check_idle("s3a");
    put(8'hA1, 1'b0, 1'b0);
    put(8'hA2, 1'b1, 1'b0);
    drain("s3b");

    // Read packet A while B is written; B commit lines up with A's last pop.
    for (int i = 0; i < 4; i++) put(8'(8'hB0 + i), 1'(i == 3), 1'b0);
    check_idle("s4a");
    budget[0] = 4; budget[1] = 4; rd_mode = 2;
    for (int i = 0; i < 3; i++) put(8'(8'hC0 + i), 1'(i == 2), 1'b0);
    check_idle("s4b");
    drain("s4c");

    // Reset with two packets stored and one open.
    for (int i = 0; i < 3; i++) put(8'(8'hD0 + i), 1'(i == 2), 1'b0);
    for (int i = 0; i < 2; i++) put(8'(8'hE0 + i), 1'(i == 1), 1'b0);
    put(8'hF0, 1'b0, 1'b0);
    put(8'hF1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q0.delete(); exp_q1.delete(); open_q.delete(); m_abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s5_empty_dut%0d", d), int'(empty_v[d]), 1);
      chk($sformatf("s5_almost_empty_dut%0d", d), int'(ae_v[d]), 1);
      chk($sformatf("s5_pkt_cnt_dut%0d", d), int'(pkt_a[d]), 0);
      chk($sformatf("s5_wr_level_dut%0d", d), int'(wr_lvl_a[d]), 0);
      chk($sformatf("s5_rd_level_dut%0d", d), int'(rd_lvl_a[d]), 0);
    end
    for (int i = 0; i < 3; i++) put(8'(8'h70 + i), 1'(i == 2), 1'b0);
    check_idle("s5a");
    drain("s5b");

    // Random packets with random reads, kept clear of full.
    rd_mode = 1;
    for (int p = 0; p < 40; p++) begin
      len = int'($urandom_range(1, 6));
      err = ($urandom_range(0, 3) == 0);
      waited = 0;
      while ((exp_q0.size() + len > 12 || exp_q1.size() + len > 12) && waited < 500) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("rand_space_wait", int'(waited < 500), 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        put(8'($urandom_range(0, 255)), 1'(i == len - 1), 1'(err && i == len - 1));
      end
    end
    check_idle("rand_a");
    drain("rand_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
